square_root_seq: RTL and testbench

//  Pipelined-handshake, multi-cycle successor to the combinational square_root used by the baggage-drop height path.

---
 rtl/sqrt_pkg.sv | 18 +
 rtl/sqrt_step.sv | 25 ++
 rtl/square_root_seq.sv | 123 ++++++++++++
 tb/tb_square_root_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and defaults for the sequential fixed-point square root.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned DEF_DATA_WIDTH      = 8;
   localparam int unsigned DEF_STEPS_PER_CYCLE = 1;

   // Root bits needed for a radicand of w bits scaled by 2^(2w).
   function automatic int unsigned root_bits(input int unsigned w);
      return (3 * w + 1) / 2;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring radix-2 root digit: brings in two radicand bits and resolves one root bit.
module sqrt_step #(
   parameter int unsigned ROOT_BITS = 12
) (
   input  logic [ROOT_BITS+1:0] rem_in,
   input  logic [ROOT_BITS-1:0] root_in,
   input  logic [1:0]           two_bits,
   output logic [ROOT_BITS+1:0] rem_out,
   output logic [ROOT_BITS-1:0] root_out
);

   logic [ROOT_BITS+1:0] rem_sh;
   logic [ROOT_BITS+1:0] trial;
   logic                 fits;

   // The remainder never exceeds 2*root, so the shifted-out top bits are always zero.
   always_comb begin
      rem_sh   = (rem_in << 2) | {{ROOT_BITS{1'b0}}, two_bits};
      trial    = {root_in, 2'b01};
      fits     = (rem_sh >= trial);
      rem_out  = fits ? (rem_sh - trial) : rem_sh;
      root_out = (root_in << 1) | {{(ROOT_BITS-1){1'b0}}, fits};
   end

endmodule

// File: rtl/square_root_seq.sv
// Multi-cycle fixed-point square root with valid/ready on both sides, one item in flight.
module square_root_seq
   import sqrt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int unsigned STEPS_PER_CYCLE = DEF_STEPS_PER_CYCLE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out,
   output logic                    busy
);

   localparam int unsigned ROOT_BITS = root_bits(DATA_WIDTH);
   localparam int unsigned RAD_W     = 2 * ROOT_BITS;
   localparam int unsigned REM_W     = ROOT_BITS + 2;
   localparam int unsigned ITER      = ROOT_BITS / STEPS_PER_CYCLE;
   localparam int unsigned CNT_W     = (ITER > 1) ? $clog2(ITER) : 1;

   if ((ROOT_BITS % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
      $error("STEPS_PER_CYCLE must divide ROOT_BITS");
   end

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [RAD_W-1:0]        rad_q, rad_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [ROOT_BITS-1:0]    root_q, root_d;
   logic [2*DATA_WIDTH-1:0] out_q, out_d;
   logic                    out_valid_q, out_valid_d;

   logic [REM_W-1:0]     rem_c  [STEPS_PER_CYCLE+1];
   logic [ROOT_BITS-1:0] root_c [STEPS_PER_CYCLE+1];

   assign rem_c[0]  = rem_q;
   assign root_c[0] = root_q;

   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
      sqrt_step #(
         .ROOT_BITS (ROOT_BITS)
      ) u_step (
         .rem_in   (rem_c[i]),
         .root_in  (root_c[i]),
         .two_bits (rad_q[RAD_W-1-2*i -: 2]),
         .rem_out  (rem_c[i+1]),
         .root_out (root_c[i+1])
      );
   end

   assign in_ready  = (state_q == IDLE) & rst_n;
   assign busy      = (state_q == CALC);
   assign out       = out_q;
   assign out_valid = out_valid_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rad_d       = rad_q;
      rem_d       = rem_q;
      root_d      = root_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               // Radicand scaled by 2^(2*DATA_WIDTH), zero-padded at the MSB end to an even width.
               rad_d                   = '0;
               rad_d[3*DATA_WIDTH-1:0] = {in, {(2*DATA_WIDTH){1'b0}}};
               rem_d                   = '0;
               root_d                  = '0;
               cnt_d                   = '0;
               state_d                 = CALC;
            end
         end
         CALC: begin
            rem_d  = rem_c[STEPS_PER_CYCLE];
            root_d = root_c[STEPS_PER_CYCLE];
            rad_d  = rad_q << (2 * STEPS_PER_CYCLE);
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               out_d                = '0;
               out_d[ROOT_BITS-1:0] = root_c[STEPS_PER_CYCLE];
               out_valid_d          = 1'b1;
               cnt_d                = '0;
               state_d              = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rad_q       <= rad_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_square_root_seq.sv
// Bench for square_root_seq at DATA_WIDTH=8, STEPS_PER_CYCLE=1 (latency 12, throughput 1/14).
module tb_square_root_seq;

   localparam int LAT = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  rad = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] dout;
   logic        busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   square_root_seq #(
      .DATA_WIDTH      (8),
      .STEPS_PER_CYCLE (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (rad),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout),
      .busy      (busy)
   );

   // Largest r with r*r <= v*2^16, by binary search.
   function automatic logic [15:0] model_root(input logic [7:0] v);
      longint unsigned target, lo, hi, mid;
      target = longint'(v) << 16;
      lo = 0;
      hi = 4096;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= target) lo = mid;
         else hi = mid;
      end
      return 16'(lo);
   endfunction

   // Offer v, scramble the input while computing, and optionally complete the output handshake.
   task automatic run_txn(input logic [7:0] v, input bit hold, output int lat,
                          output logic [15:0] res, output bit timed_out);
      int guard;
      guard = 0;
      timed_out = 1'b0;
      rad = v;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rad = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) timed_out = 1'b1;
      res = dout;
      if (!hold) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      total++;
      if (dout !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h exp=0000", dout); end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_latency();
      rad = 8'd4;
      in_valid = 1'b1;
      for (int j = 1; j <= LAT + 1; j++) begin
         @(negedge clk);
         in_valid = 1'b0;
         rad = 8'($urandom);
         total++;
         if (in_ready !== 1'b0) begin
            bad++; $display("FAIL latency_in_ready cyc=%0d got=%b exp=0", j, in_ready);
         end
         total++;
         if (out_valid !== (j == LAT + 1)) begin
            bad++; $display("FAIL latency_out_valid cyc=%0d got=%b exp=%b", j, out_valid, j == LAT + 1);
         end
      end
      total++;
      if (dout !== 16'h0200) begin bad++; $display("FAIL latency_out got=%h exp=0200", dout); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_corners();
      logic [7:0]  vals [5] = '{8'd255, 8'd2, 8'd1, 8'd0, 8'd4};
      logic [15:0] exps [5] = '{16'h0FF7, 16'h016A, 16'h0100, 16'h0000, 16'h0200};
      int lat;
      logic [15:0] res;
      bit to;
      for (int i = 0; i < 5; i++) begin
         run_txn(vals[i], 1'b0, lat, res, to);
         total++;
         if (to || res !== exps[i]) begin
            bad++; $display("FAIL corner in=%0d got=%h exp=%h timeout=%0d", vals[i], res, exps[i], to);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [15:0] res;
      bit to;
      run_txn(8'd77, 1'b1, lat, res, to);
      total++;
      if (to || res !== model_root(8'd77)) begin
         bad++; $display("FAIL bp_result got=%h exp=%h", res, model_root(8'd77));
      end
      in_valid = 1'b1;
      rad = 8'd13;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || dout !== res || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/%h/0", j, out_valid, dout, in_ready, res);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=%b/%b exp=0/1", out_valid, in_ready);
      end
      total++;
      if (dout !== res) begin bad++; $display("FAIL bp_out_kept got=%h exp=%h", dout, res); end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      logic [15:0] res;
      bit to;
      rad = 8'd200;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b exp=1", busy); end
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || dout !== 16'h0000) begin
         bad++; $display("FAIL midrst_state got=%b/%b/%h exp=0/0/0000", out_valid, busy, dout);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", in_ready); end
      run_txn(8'd9, 1'b0, lat, res, to);
      total++;
      if (to || res !== 16'h0300 || lat != LAT) begin
         bad++; $display("FAIL midrst_after got=%h lat=%0d exp=0300 lat=%0d", res, lat, LAT);
      end
   endtask

   task automatic test_exhaustive();
      int lat;
      logic [15:0] res;
      bit to;
      for (int v = 0; v < 256; v++) begin
         run_txn(8'(v), 1'b0, lat, res, to);
         total++;
         if (to || res !== model_root(8'(v)) || lat != LAT) begin
            bad++;
            $display("FAIL exhaustive in=%0d got=%h lat=%0d exp=%h lat=%0d",
                     v, res, lat, model_root(8'(v)), LAT);
         end
      end
   endtask

   task automatic test_random_backpressure();
      int lat;
      logic [15:0] res;
      bit to;
      logic [7:0] v;
      int d;
      for (int n = 0; n < 20; n++) begin
         v = 8'($urandom_range(0, 255));
         d = $urandom_range(0, 4);
         run_txn(v, 1'b1, lat, res, to);
         total++;
         if (to || res !== model_root(v)) begin
            bad++; $display("FAIL rand in=%0d got=%h exp=%h", v, res, model_root(v));
         end
         for (int j = 0; j < d; j++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || dout !== res) begin
               bad++; $display("FAIL rand_hold got=%b/%h exp=1/%h", out_valid, dout, res);
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q [$];
      logic [15:0] e;
      int last_acc;
      int accepts;
      last_acc = -1;
      accepts = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 72; c++) begin
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            total++;
            if (dout !== e) begin bad++; $display("FAIL b2b_result got=%h exp=%h", dout, e); end
         end
         if (in_ready && out_valid) begin
            total++; bad++; $display("FAIL b2b_accept_in_done got=1 exp=0");
         end
         if (!in_ready) rad = 8'($urandom);
         if (in_ready) begin
            if (last_acc >= 0) begin
               total++;
               if (c - last_acc != LAT + 2) begin
                  bad++; $display("FAIL b2b_gap got=%0d exp=%0d", c - last_acc, LAT + 2);
               end
            end
            last_acc = c;
            accepts++;
            exp_q.push_back(model_root(rad));
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            total++;
            if (dout !== e) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", dout, e); end
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      total++;
      if (accepts != 6 || exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_count got=%0d/%0d exp=6/0", accepts, exp_q.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_latency();
      test_corners();
      test_backpressure();
      test_reset_mid_calc();
      test_exhaustive();
      test_random_backpressure();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
